// File: rtl/mmsp430_trace_capture.sv
// MSP430 retire-stream trace capture: holds the last retired instruction and
// emits a branch record whenever control flow leaves the sequential path.
module mmsp430_trace_capture #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  retire,
  input  logic [15:0]           retire_pc,
  input  logic [2:0]            retire_len,
  input  logic                  retire_call,
  input  logic                  retire_ret,
  input  logic                  retire_reti,
  input  logic                  retire_jump,
  output logic                  trace_valid,
  output logic [ADDR_WIDTH-1:0] trace_pc,
  output logic [ADDR_WIDTH-1:0] trace_jbtarget,
  output logic                  trace_jal,
  output logic                  trace_jr,
  output logic [15:0]           rec_count,
  output logic                  err_len
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [2:0]  pend_len_q, pend_len_d;
  logic        pend_call_q, pend_call_d;
  logic        pend_ret_q, pend_ret_d;
  logic        pend_reti_q, pend_reti_d;
  logic        pend_jump_q, pend_jump_d;

  logic        trace_valid_q, trace_valid_d;
  logic [15:0] trace_pc_q, trace_pc_d;
  logic [15:0] trace_jbtarget_q, trace_jbtarget_d;
  logic        trace_jal_q, trace_jal_d;
  logic        trace_jr_q, trace_jr_d;
  logic [15:0] rec_count_q, rec_count_d;
  logic        err_len_q, err_len_d;

  logic        len_ok;
  logic [2:0]  len_norm;
  logic [15:0] expected;
  logic        emit;

  always_comb begin
    len_ok   = (retire_len == 3'd2) || (retire_len == 3'd4) || (retire_len == 3'd6);
    len_norm = len_ok ? retire_len : 3'd2;
    expected = pend_pc_q + {13'd0, pend_len_q};
    emit     = (state_q == PEND) &&
               (pend_call_q || pend_ret_q || pend_reti_q || pend_jump_q ||
                (retire_pc != expected));
  end

  always_comb begin
    state_d          = state_q;
    pend_pc_d        = pend_pc_q;
    pend_len_d       = pend_len_q;
    pend_call_d      = pend_call_q;
    pend_ret_d       = pend_ret_q;
    pend_reti_d      = pend_reti_q;
    pend_jump_d      = pend_jump_q;
    trace_valid_d    = 1'b0;
    trace_pc_d       = trace_pc_q;
    trace_jbtarget_d = trace_jbtarget_q;
    trace_jal_d      = trace_jal_q;
    trace_jr_d       = trace_jr_q;
    rec_count_d      = rec_count_q;
    err_len_d        = err_len_q;

    // Disabling tracing abandons the held instruction outright.
    if (!enable) begin
      state_d     = IDLE;
      pend_pc_d   = 16'd0;
      pend_len_d  = 3'd0;
      pend_call_d = 1'b0;
      pend_ret_d  = 1'b0;
      pend_reti_d = 1'b0;
      pend_jump_d = 1'b0;
    end else if (retire) begin
      if (!len_ok) begin
        err_len_d = 1'b1;
      end
      if (emit) begin
        trace_valid_d    = 1'b1;
        trace_pc_d       = pend_pc_q;
        trace_jbtarget_d = retire_pc;
        trace_jal_d      = pend_call_q;
        trace_jr_d       = pend_ret_q | pend_reti_q;
        rec_count_d      = rec_count_q + 16'd1;
      end
      state_d     = PEND;
      pend_pc_d   = retire_pc;
      pend_len_d  = len_norm;
      pend_call_d = retire_call;
      pend_ret_d  = retire_ret;
      pend_reti_d = retire_reti;
      pend_jump_d = retire_jump;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pend_pc_q        <= 16'd0;
      pend_len_q       <= 3'd0;
      pend_call_q      <= 1'b0;
      pend_ret_q       <= 1'b0;
      pend_reti_q      <= 1'b0;
      pend_jump_q      <= 1'b0;
      trace_valid_q    <= 1'b0;
      trace_pc_q       <= 16'd0;
      trace_jbtarget_q <= 16'd0;
      trace_jal_q      <= 1'b0;
      trace_jr_q       <= 1'b0;
      rec_count_q      <= 16'd0;
      err_len_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_pc_q        <= pend_pc_d;
      pend_len_q       <= pend_len_d;
      pend_call_q      <= pend_call_d;
      pend_ret_q       <= pend_ret_d;
      pend_reti_q      <= pend_reti_d;
      pend_jump_q      <= pend_jump_d;
      trace_valid_q    <= trace_valid_d;
      trace_pc_q       <= trace_pc_d;
      trace_jbtarget_q <= trace_jbtarget_d;
      trace_jal_q      <= trace_jal_d;
      trace_jr_q       <= trace_jr_d;
      rec_count_q      <= rec_count_d;
      err_len_q        <= err_len_d;
    end
  end

  // Addresses live in a 16-bit space; the wider bus is zero-extended.
  assign trace_valid    = trace_valid_q;
  assign trace_pc       = ADDR_WIDTH'(trace_pc_q);
  assign trace_jbtarget = ADDR_WIDTH'(trace_jbtarget_q);
  assign trace_jal      = trace_jal_q;
  assign trace_jr       = trace_jr_q;
  assign rec_count      = rec_count_q;
  assign err_len        = err_len_q;

endmodule

// File: tb/tb_mmsp430_trace_capture.sv
// Self-checking bench for mmsp430_trace_capture: directed scenarios plus
// randomized retire streams compared against a behavioural branch-trace model.
module tb_mmsp430_trace_capture;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          retire;
  logic [15:0]   retire_pc;
  logic [2:0]    retire_len;
  logic          retire_call;
  logic          retire_ret;
  logic          retire_reti;
  logic          retire_jump;
  logic          trace_valid;
  logic [AW-1:0] trace_pc;
  logic [AW-1:0] trace_jbtarget;
  logic          trace_jal;
  logic          trace_jr;
  logic [15:0]   rec_count;
  logic          err_len;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: the instruction waiting for its successor, and the expected outputs.
  bit          mHavePend;
  int          mPc, mLen;
  bit          mCall, mRet, mReti, mJump;
  bit          expValid, expJal, expJr, expErr;
  int          expPc, expTgt, expCount;

  mmsp430_trace_capture #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .retire(retire),
    .retire_pc(retire_pc), .retire_len(retire_len),
    .retire_call(retire_call), .retire_ret(retire_ret),
    .retire_reti(retire_reti), .retire_jump(retire_jump),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_jbtarget(trace_jbtarget), .trace_jal(trace_jal),
    .trace_jr(trace_jr), .rec_count(rec_count), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ":valid"}, 64'(trace_valid), 64'(expValid));
    checkOutput({ctx, ":pc"}, 64'(trace_pc), 64'(expPc));
    checkOutput({ctx, ":jbtarget"}, 64'(trace_jbtarget), 64'(expTgt));
    checkOutput({ctx, ":jal"}, 64'(trace_jal), 64'(expJal));
    checkOutput({ctx, ":jr"}, 64'(trace_jr), 64'(expJr));
    checkOutput({ctx, ":rec_count"}, 64'(rec_count), 64'(expCount));
    checkOutput({ctx, ":err_len"}, 64'(err_len), 64'(expErr));
  endtask

  // One clock of the specified behaviour, applied to the inputs the DUT just sampled.
  task automatic modelStep();
    int  len;
    int  nextAddr;
    expValid = 0;
    if (!enable) begin
      mHavePend = 0;
    end else if (retire) begin
      len = int'(retire_len);
      if (len != 2 && len != 4 && len != 6) begin
        len = 2;
        expErr = 1;
      end
      if (mHavePend) begin
        nextAddr = (mPc + mLen) % 65536;
        if (mCall || mRet || mReti || mJump || int'(retire_pc) != nextAddr) begin
          expValid = 1;
          expPc    = mPc;
          expTgt   = int'(retire_pc);
          expJal   = mCall;
          expJr    = mRet || mReti;
          expCount = (expCount + 1) % 65536;
        end
      end
      mHavePend = 1;
      mPc   = int'(retire_pc);
      mLen  = len;
      mCall = retire_call;
      mRet  = retire_ret;
      mReti = retire_reti;
      mJump = retire_jump;
    end
  endtask

  task automatic modelReset();
    mHavePend = 0;
    mPc = 0; mLen = 0;
    mCall = 0; mRet = 0; mReti = 0; mJump = 0;
    expValid = 0; expPc = 0; expTgt = 0; expJal = 0; expJr = 0;
    expCount = 0; expErr = 0;
  endtask

  task automatic applyStimulus(input bit en, input bit ret, input int pc, input int len,
                               input bit call, input bit rt, input bit reti, input bit jump,
                               input bit doCheck, input string ctx);
    enable      = en;
    retire      = ret;
    retire_pc   = 16'(pc);
    retire_len  = 3'(len);
    retire_call = call;
    retire_ret  = rt;
    retire_reti = reti;
    retire_jump = jump;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    if (doCheck) checkAll(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 16'h5555, 2, 1, 1, 1, 1, 1, ctx);
  endtask

  task automatic doReset(input string ctx);
    @(negedge clk);
    retire = 0;
    rst_n  = 1'b0;
    #1;
    modelReset();
    checkAll(ctx);
    @(negedge clk);
    checkAll(ctx);
    rst_n = 1'b1;
  endtask

  initial begin
    int  pc, len, sel, guard;
    bit  en, ret, call, rt, reti, jump;

    rst_n = 1'b0;
    enable = 0; retire = 0; retire_pc = 0; retire_len = 3'd2;
    retire_call = 0; retire_ret = 0; retire_reti = 0; retire_jump = 0;
    modelReset();
    doReset("reset");

    // Straight-line code
    applyStimulus(1, 1, 16'hC000, 2, 0, 0, 0, 0, 1, "seq");
    applyStimulus(1, 1, 16'hC002, 4, 0, 0, 0, 0, 1, "seq");
    applyStimulus(1, 1, 16'hC006, 2, 0, 0, 0, 0, 1, "seq");
    checkOutput("seq_valid", 64'(trace_valid), 64'd0);
    checkOutput("seq_count", 64'(rec_count), 64'd0);

    // Call
    applyStimulus(1, 1, 16'hC010, 4, 1, 0, 0, 0, 1, "call");
    applyStimulus(1, 1, 16'hD000, 2, 0, 0, 0, 0, 1, "call");
    checkOutput("call_valid", 64'(trace_valid), 64'd1);
    checkOutput("call_pc", 64'(trace_pc), 64'h0000_C010);
    checkOutput("call_tgt", 64'(trace_jbtarget), 64'h0000_D000);
    checkOutput("call_jal", 64'(trace_jal), 64'd1);
    checkOutput("call_jr", 64'(trace_jr), 64'd0);
    idle(3, "hold");
    checkOutput("hold_pc", 64'(trace_pc), 64'h0000_C010);

    // Interrupt entry and RETI
    applyStimulus(1, 1, 16'hC020, 2, 0, 0, 0, 0, 1, "irq");
    applyStimulus(1, 1, 16'hFFE0, 2, 0, 0, 1, 0, 1, "irq");
    checkOutput("irq_valid", 64'(trace_valid), 64'd1);
    checkOutput("irq_jal", 64'(trace_jal), 64'd0);
    checkOutput("irq_jr", 64'(trace_jr), 64'd0);
    applyStimulus(1, 1, 16'hC022, 2, 0, 0, 0, 0, 1, "reti");
    checkOutput("reti_valid", 64'(trace_valid), 64'd1);
    checkOutput("reti_jr", 64'(trace_jr), 64'd1);
    checkOutput("reti_pc", 64'(trace_pc), 64'h0000_FFE0);

    // Address wrap
    applyStimulus(1, 1, 16'hFFFE, 2, 0, 0, 0, 0, 1, "wrap");
    applyStimulus(1, 1, 16'h0000, 2, 0, 0, 0, 0, 1, "wrap");
    checkOutput("wrap_norec", 64'(trace_valid), 64'd0);

    // Enable drop following a pending CALL
    applyStimulus(1, 1, 16'hC100, 4, 1, 0, 0, 0, 1, "en");
    applyStimulus(0, 1, 16'hD000, 2, 0, 0, 0, 0, 1, "en");
    checkOutput("en_drop", 64'(trace_valid), 64'd0);
    applyStimulus(1, 1, 16'hE000, 2, 0, 0, 0, 1, 1, "en");
    checkOutput("en_loadonly", 64'(trace_valid), 64'd0);

    // Illegal length
    applyStimulus(1, 1, 16'hE100, 3, 0, 0, 0, 0, 1, "len");
    applyStimulus(1, 1, 16'hE102, 2, 0, 0, 0, 0, 1, "len");
    checkOutput("len_err", 64'(err_len), 64'd1);
    checkOutput("len_seq", 64'(trace_valid), 64'd0);
    idle(4, "len_hold");
    applyStimulus(1, 1, 16'hE104, 2, 0, 0, 0, 0, 1, "len_hold");
    checkOutput("len_keep", 64'(err_len), 64'd1);

    // Reset mid-operation drops the pending CALL
    applyStimulus(1, 1, 16'hF000, 2, 1, 0, 0, 0, 1, "midrst");
    doReset("midrst");
    checkOutput("midrst_err", 64'(err_len), 64'd0);
    applyStimulus(1, 1, 16'h1234, 2, 0, 0, 0, 0, 1, "midrst");
    checkOutput("midrst_norec", 64'(trace_valid), 64'd0);

    // Randomized retire streams
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      ret = ($urandom_range(0, 9) < 7);
      if (mHavePend && $urandom_range(0, 9) < 6) pc = (mPc + mLen) % 65536;
      else pc = 2 * int'($urandom_range(0, 32767));
      sel = int'($urandom_range(0, 2));
      len = 2 + 2 * sel;
      if (en && $urandom_range(0, 19) == 0) len = int'($urandom_range(0, 7));
      sel  = int'($urandom_range(0, 9));
      call = (sel == 0);
      rt   = (sel == 1);
      reti = (sel == 2);
      jump = (sel == 3);
      applyStimulus(en, ret, pc, len, call, rt, reti, jump, 1, "rand");
    end

    // rec_count rollover via a long run of jumps
    doReset("cnt");
    guard = 0;
    while (expCount != 65535 && guard < 70000) begin
      applyStimulus(1, 1, 2 * int'($urandom_range(0, 32767)), 2, 0, 0, 0, 1, 0, "cnt");
      guard++;
    end
    checkOutput("cnt_preload", 64'(rec_count), 64'hFFFF);
    applyStimulus(1, 1, 16'h4000, 2, 0, 0, 0, 1, 1, "cnt");
    checkOutput("cnt_wrap", 64'(rec_count), 64'h0000);
    checkOutput("cnt_valid", 64'(trace_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mmsp430_trace_capture.md
MMSP430_TRACE_CAPTURE -- requirements
Module: mmsp430_trace_capture

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of trace_pc and trace_jbtarget; values 16 and above SHALL be legal.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1, trace capture enable from the debug control register.
REQ-005 SHALL have port retire, input, 1, one-cycle strobe for each instruction the MSP430 core completes.
REQ-006 SHALL have port retire_pc, input, 16, the byte address of the retiring instruction.
REQ-007 SHALL have port retire_len, input, 3, the retiring instruction length in bytes; legal values are 2, 4 and 6.
REQ-008 SHALL have port retire_call, input, 1, the retiring instruction is CALL.
REQ-009 SHALL have port retire_ret, input, 1, the retiring instruction is RET.
REQ-010 SHALL have port retire_reti, input, 1, the retiring instruction is RETI.
REQ-011 SHALL have port retire_jump, input, 1, the retiring instruction is a jump or a direct write to PC.
REQ-012 SHALL have port trace_valid, output, 1, a one-cycle record strobe into the trace_exec valid field.
REQ-013 SHALL have port trace_pc, output, ADDR_WIDTH, the source instruction address, zero-extended.
REQ-014 SHALL have port trace_jbtarget, output, ADDR_WIDTH, the address actually executed next, zero-extended.
REQ-015 SHALL have port trace_jal, output, 1, the source instruction was CALL.
REQ-016 SHALL have port trace_jr, output, 1, the source instruction was RET or RETI.
REQ-017 SHALL have port rec_count, output, 16, the number of records emitted, wrapping.
REQ-018 SHALL have port err_len, output, 1, sticky flag, set on an illegal retire_len.

Function
REQ-019 SHALL implement a two-state FSM with states IDLE and PEND; PEND means one retired instruction is held in the pending registers.
REQ-020 In IDLE, retire=1 with enable=1 SHALL load the pending registers (pc, len, call, ret, reti, jump) from the retire_* inputs and move the FSM to PEND.
REQ-021 In PEND, retire=1 with enable=1 SHALL compute expected = pend_pc + pend_len as a 16-bit add that wraps modulo 2^16.
REQ-022 In that same cycle the pending registers SHALL be replaced by the new retire_* values, and the FSM SHALL stay in PEND.
REQ-023 An emit condition SHALL exist when any of pend_call, pend_ret, pend_reti, pend_jump is set, or when retire_pc != expected (interrupt or other discontinuity).
REQ-024 On an emit condition, the cycle after the retire SHALL show trace_valid=1, trace_pc=pend_pc, trace_jbtarget=retire_pc, trace_jal=pend_call and trace_jr=pend_ret|pend_reti.
REQ-025 trace_valid SHALL be high for exactly one cycle per record.
REQ-026 trace_pc, trace_jbtarget, trace_jal and trace_jr SHALL hold their last values when trace_valid=0.
REQ-027 Record latency SHALL be exactly 1 cycle from the consuming retire strobe; back-to-back retires SHALL be able to produce records in consecutive cycles.
REQ-028 A sequential instruction that matches expected and has no flags set SHALL produce no record.
REQ-029 rec_count SHALL increment by 1 for each emitted record and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 A retire_len of 0, 1, 3, 5 or 7 SHALL be treated as 2 and SHALL set err_len; err_len SHALL be cleared only by reset.
REQ-031 enable=0 SHALL force the FSM to IDLE, discard the pending instruction, and emit no record in the following cycle, even if retire=1 in the same cycle.
REQ-032 retire=0 SHALL leave the FSM state and the pending registers unchanged, regardless of how many idle cycles pass.
REQ-033 The upper ADDR_WIDTH-16 bits of trace_pc and trace_jbtarget SHALL always be 0.

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE and the pending registers SHALL be 0.
REQ-035 While rst_n=0, trace_valid, trace_pc, trace_jbtarget, trace_jal, trace_jr, rec_count and err_len SHALL all be 0.
REQ-036 Reset asserted mid-operation SHALL drop the pending instruction; no record SHALL be emitted for it after rst_n deasserts.

Verification
REQ-037 Straight-line code: retires at 0xC000/len2, 0xC002/len4, 0xC006/len2 -> no trace_valid, rec_count=0.
REQ-038 Call: CALL at 0xC010/len4, then retire at 0xD000 -> the next cycle shows trace_valid=1, trace_pc=0x0000C010, trace_jbtarget=0x0000D000, jal=1, jr=0.
REQ-039 Interrupt: unflagged instruction at 0xC020/len2, then retire at 0xFFE0 -> a record with jal=0, jr=0; RETI back to 0xC022 -> a record with jr=1.
REQ-040 Wrap: instruction at 0xFFFE/len2, then retire at 0x0000 -> no record; with rec_count preloaded to 0xFFFF, one more record -> rec_count=0x0000.
REQ-041 enable drops in the same cycle as a retire that follows a pending CALL -> no record; after re-enable, the first retire only loads the pending registers.
REQ-042 retire_len=3 -> err_len=1 and the next address is computed as pc+2; err_len stays 1 until rst_n=0.
